// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU issue path: opcodes, sequencer states and instruction field positions.
package cpu_pkg;

  localparam logic [7:0] OP_FWD       = 8'h00;
  localparam logic [7:0] OP_ADD       = 8'h01;
  localparam logic [7:0] OP_SUB       = 8'h02;
  localparam logic [7:0] OP_AND       = 8'h03;
  localparam logic [7:0] OP_OR        = 8'h04;
  localparam logic [7:0] OP_RSV       = 8'h05;
  localparam logic [7:0] OP_MAX_LEGAL = 8'h05;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 24;
  localparam int DST_HI = 23;
  localparam int DST_LO = 16;
  localparam int SR1_HI = 15;
  localparam int SR1_LO = 8;
  localparam int SR2_HI = 7;
  localparam int SR2_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP1  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Anything above the reserved no-op opcode must never reach the core.
  function automatic logic is_illegal(input logic [31:0] word);
    return (word[OPC_HI:OPC_LO] > OP_MAX_LEGAL);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is refused when full regardless of a same-cycle pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == (AW+1)'(DEPTH));
  assign empty  = (count_r == (AW+1)'(0));
  assign count  = count_r;
  assign rdata  = mem_r[rd_ptr_r];
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/cpu_issue_ctrl.sv
// Issue sequencer: queues host-loaded instruction words and feeds them to the core under
// run / single-step / halt control, trapping illegal opcodes before they are driven.
module cpu_issue_ctrl
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] NOP_WORD = 32'h0500_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  input  logic [31:0]            load_data,
  output logic                   load_ready,
  input  logic                   start,
  input  logic                   step,
  input  logic                   halt_req,
  output logic [31:0]            instruction,
  output logic                   issue_valid,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            issued_cnt,
  output logic                   err
);

  state_t       state_r;
  state_t       next_state_s;
  logic [31:0]  head_s;
  logic         full_s;
  logic         empty_s;
  logic         pop_s;
  logic         issue_s;
  logic         trap_s;
  logic         clr_err_s;
  logic [31:0]  instr_r;
  logic         issue_valid_r;
  logic [15:0]  issued_cnt_r;
  logic         err_r;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (load_valid),
    .pop   (pop_s),
    .wdata (load_data),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count)
  );

  assign load_ready  = !full_s;
  assign instruction = instr_r;
  assign issue_valid = issue_valid_r;
  assign state       = state_r;
  assign issued_cnt  = issued_cnt_r;
  assign err         = err_r;

  // Next-state and issue decisions; HALT_REQ outranks START, which outranks STEP.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    issue_s      = 1'b0;
    trap_s       = 1'b0;
    clr_err_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (halt_req) begin
          next_state_s = state_r;
        end else if (start) begin
          next_state_s = ST_RUN;
          clr_err_s    = 1'b1;
        end else if (step) begin
          next_state_s = ST_STEP1;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          next_state_s = ST_HALTED;
        end else if (!empty_s) begin
          pop_s = 1'b1;
          if (is_illegal(head_s)) begin
            trap_s       = 1'b1;
            next_state_s = ST_HALTED;
          end else begin
            issue_s = 1'b1;
          end
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_STEP1: begin
        next_state_s = ST_HALTED;
        if (!halt_req && !empty_s) begin
          pop_s = 1'b1;
          if (is_illegal(head_s)) begin
            trap_s = 1'b1;
          end else begin
            issue_s = 1'b1;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, issue register, issue counter and sticky trap flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      instr_r       <= NOP_WORD;
      issue_valid_r <= 1'b0;
      issued_cnt_r  <= 16'd0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      instr_r       <= issue_s ? head_s : NOP_WORD;
      issue_valid_r <= issue_s;
      if (issue_s) begin
        issued_cnt_r <= issued_cnt_r + 16'd1;
      end
      if (trap_s) begin
        err_r <= 1'b1;
      end else if (clr_err_s) begin
        err_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_issue_ctrl.sv
// Directed bench for cpu_issue_ctrl: run, back-pressure, stepping, halt priority, trap and async reset.
module tb_cpu_issue_ctrl;

  localparam logic [31:0] NOP = 32'h0500_0000;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        start;
  logic        step;
  logic        halt_req;
  logic [31:0] instruction;
  logic        issue_valid;
  logic [1:0]  state;
  logic [3:0]  count;
  logic [15:0] issued_cnt;
  logic        err;

  int total;
  int bad;

  cpu_issue_ctrl #(.DEPTH(8), .NOP_WORD(32'h0500_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .start       (start),
    .step        (step),
    .halt_req    (halt_req),
    .instruction (instruction),
    .issue_valid (issue_valid),
    .state       (state),
    .count       (count),
    .issued_cnt  (issued_cnt),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 32'd0;
    start      = 1'b0;
    step       = 1'b0;
    halt_req   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (instruction !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instruction, NOP); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_iv got=%b exp=0", issue_valid); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (issued_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", issued_cnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
  endtask

  task automatic test_run();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h0000_002A;
    exp_w[1] = 32'h0101_0000;
    exp_w[2] = 32'h0202_0100;
    do_reset();
    for (int i = 0; i < 3; i++) push_word(exp_w[i]);
    total++; if (count !== 4'd3) begin bad++; $display("FAIL run_loaded got=%0d exp=3", count); end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (state !== 2'd1 || issue_valid !== 1'b0) begin bad++; $display("FAIL run_enter state=%0d iv=%b exp 1/0", state, issue_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (issue_valid !== 1'b1 || instruction !== exp_w[i]) begin
        bad++; $display("FAIL run_issue%0d got iv=%b w=%h exp iv=1 w=%h", i, issue_valid, instruction, exp_w[i]);
      end
    end
    tick();
    total++; if (issue_valid !== 1'b0 || instruction !== NOP) begin bad++; $display("FAIL run_bubble got iv=%b w=%h exp 0/%h", issue_valid, instruction, NOP); end
    total++; if (issued_cnt !== 16'd3) begin bad++; $display("FAIL run_cnt got=%0d exp=3", issued_cnt); end
    total++; if (state !== 2'd1 || count !== 4'd0) begin bad++; $display("FAIL run_final state=%0d count=%0d exp 1/0", state, count); end
  endtask

  task automatic test_full();
    int maxc;
    maxc = 0;
    do_reset();
    load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load_data = 32'h0000_0010 + 32'(i);
      tick();
      if (int'(count) > maxc) maxc = int'(count);
    end
    total++; if (count !== 4'd8 || load_ready !== 1'b0) begin bad++; $display("FAIL full_8 count=%0d ready=%b exp 8/0", count, load_ready); end
    load_data = 32'h0000_0099;
    tick();
    total++; if (count !== 4'd8) begin bad++; $display("FAIL full_hold count=%0d exp=8", count); end
    step = 1'b1;
    tick();
    step = 1'b0;
    total++; if (state !== 2'd2 || count !== 4'd8) begin bad++; $display("FAIL full_step1 state=%0d count=%0d exp 2/8", state, count); end
    tick();
    total++; if (count !== 4'd7 || issue_valid !== 1'b1 || instruction !== 32'h0000_0010) begin
      bad++; $display("FAIL full_pop count=%0d iv=%b w=%h exp 7/1/00000010", count, issue_valid, instruction);
    end
    total++; if (load_ready !== 1'b1 || state !== 2'd3) begin bad++; $display("FAIL full_after ready=%b state=%0d exp 1/3", load_ready, state); end
    tick();
    if (int'(count) > maxc) maxc = int'(count);
    load_valid = 1'b0;
    total++; if (count !== 4'd8) begin bad++; $display("FAIL full_ninth count=%0d exp=8", count); end
    total++; if (maxc > 8) begin bad++; $display("FAIL full_max got=%0d exp<=8", maxc); end
  endtask

  task automatic test_step();
    logic [31:0] exp_w [2];
    exp_w[0] = 32'h0311_2233;
    exp_w[1] = 32'h0444_5566;
    do_reset();
    push_word(exp_w[0]);
    push_word(exp_w[1]);
    push_word(32'h0177_8899);
    for (int i = 0; i < 2; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      total++; if (state !== 2'd2) begin bad++; $display("FAIL step%0d_enter state=%0d exp=2", i, state); end
      tick();
      total++; if (issue_valid !== 1'b1 || instruction !== exp_w[i]) begin
        bad++; $display("FAIL step%0d_issue iv=%b w=%h exp 1/%h", i, issue_valid, instruction, exp_w[i]);
      end
      total++; if (state !== 2'd3) begin bad++; $display("FAIL step%0d_halted state=%0d exp=3", i, state); end
      tick();
      total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL step%0d_once iv=%b exp=0", i, issue_valid); end
    end
    total++; if (count !== 4'd1 || issued_cnt !== 16'd2) begin bad++; $display("FAIL step_count count=%0d cnt=%0d exp 1/2", count, issued_cnt); end
  endtask

  task automatic test_step_empty();
    do_reset();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    total++; if (state !== 2'd3 || issue_valid !== 1'b0 || issued_cnt !== 16'd0) begin
      bad++; $display("FAIL step_empty state=%0d iv=%b cnt=%0d exp 3/0/0", state, issue_valid, issued_cnt);
    end
  endtask

  task automatic test_halt_priority();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'h0100_0000 + 32'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (state !== 2'd1 || count !== 4'd4) begin bad++; $display("FAIL halt_pre state=%0d count=%0d exp 1/4", state, count); end
    halt_req = 1'b1;
    start    = 1'b1;
    tick();
    halt_req = 1'b0;
    start    = 1'b0;
    total++; if (issue_valid !== 1'b0 || instruction !== NOP) begin bad++; $display("FAIL halt_noissue iv=%b w=%h exp 0/%h", issue_valid, instruction, NOP); end
    total++; if (state !== 2'd3 || count !== 4'd4) begin bad++; $display("FAIL halt_state state=%0d count=%0d exp 3/4", state, count); end
  endtask

  task automatic test_trap();
    do_reset();
    push_word(32'h0111_2233);
    push_word(32'h0700_0000);
    push_word(32'h0244_5566);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total++; if (issue_valid !== 1'b1 || instruction !== 32'h0111_2233) begin bad++; $display("FAIL trap_first iv=%b w=%h exp 1/01112233", issue_valid, instruction); end
    tick();
    total++; if (issue_valid !== 1'b0 || instruction !== NOP) begin bad++; $display("FAIL trap_drop iv=%b w=%h exp 0/%h", issue_valid, instruction, NOP); end
    total++; if (err !== 1'b1 || state !== 2'd3) begin bad++; $display("FAIL trap_err err=%b state=%0d exp 1/3", err, state); end
    total++; if (count !== 4'd1 || issued_cnt !== 16'd1) begin bad++; $display("FAIL trap_count count=%0d cnt=%0d exp 1/1", count, issued_cnt); end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (err !== 1'b0 || state !== 2'd1) begin bad++; $display("FAIL trap_restart err=%b state=%0d exp 0/1", err, state); end
    tick();
    total++; if (issue_valid !== 1'b1 || instruction !== 32'h0244_5566 || issued_cnt !== 16'd2) begin
      bad++; $display("FAIL trap_resume iv=%b w=%h cnt=%0d exp 1/02445566/2", issue_valid, instruction, issued_cnt);
    end
  endtask

  task automatic test_opcode_boundary();
    do_reset();
    push_word(32'h05AB_CDEF);
    push_word(32'h0600_0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total++; if (issue_valid !== 1'b1 || instruction !== 32'h05AB_CDEF) begin bad++; $display("FAIL op05_issue iv=%b w=%h exp 1/05abcdef", issue_valid, instruction); end
    tick();
    total++; if (issue_valid !== 1'b0 || err !== 1'b1 || state !== 2'd3 || count !== 4'd0) begin
      bad++; $display("FAIL op06_trap iv=%b err=%b state=%0d count=%0d exp 0/1/3/0", issue_valid, err, state, count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) push_word(32'h0200_0000 + 32'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total++; if (state !== 2'd1 || issue_valid !== 1'b1 || count !== 4'd4) begin
      bad++; $display("FAIL ares_pre state=%0d iv=%b count=%0d exp 1/1/4", state, issue_valid, count);
    end
    #2;
    reset = 1'b1;
    #1;
    total++; if (state !== 2'd0 || count !== 4'd0) begin bad++; $display("FAIL ares_state state=%0d count=%0d exp 0/0", state, count); end
    total++; if (instruction !== NOP || issue_valid !== 1'b0) begin bad++; $display("FAIL ares_out w=%h iv=%b exp %h/0", instruction, issue_valid, NOP); end
    total++; if (issued_cnt !== 16'd0 || load_ready !== 1'b1) begin bad++; $display("FAIL ares_cnt cnt=%0d ready=%b exp 0/1", issued_cnt, load_ready); end
    #1;
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_run();
    test_full();
    test_step();
    test_step_empty();
    test_halt_priority();
    test_trap();
    test_opcode_boundary();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
